// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - IF/LS winner selection, optional starvation guard (MEM_ARB_STARVE_GUARD_EN)
module mem_arb_select
  import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
`endif
  input  logic   if_req,
  input  logic   ls_req,
  output logic   any_req,
  output owner_t winner
);

  assign any_req = if_req | ls_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_q;
  logic            starve_hit;

  assign starve_hit = if_req && (starve_q >= SC_W'(STARVE_MAX));

  // LS wins unless IF has been passed over STARVE_MAX times in a row
  always_comb begin
    winner = OWN_IF;
    if (ls_req && !starve_hit) winner = OWN_LS;
  end

  // Count LS wins that left IF waiting; any IF win restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (arb_en && any_req) begin
      if (winner == OWN_IF) starve_q <= '0;
      else if (if_req)      starve_q <= starve_q + SC_W'(1);
    end
  end
`else
  // Fixed priority: LS always beats IF
  always_comb begin
    winner = OWN_IF;
    if (ls_req) winner = OWN_LS;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port sequencer shared by IF and LS (option: MEM_ARB_STARVE_GUARD_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
  end

  arb_state_t        state_q, state_d;
  owner_t            owner_q;
  owner_t            winner;
  logic              any_req;
  logic              arb_en;
  logic              last_wait;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  // New work is only accepted from IDLE or straight out of RESP
  assign arb_en    = (state_q == IDLE) || (state_q == RESP);
  assign last_wait = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  mem_arb_select
`ifdef MEM_ARB_STARVE_GUARD_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
  u_select (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
`endif
    .if_req  (if_req),
    .ls_req  (ls_req),
    .any_req (any_req),
    .winner  (winner)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode: IDLE/RESP arbitrate, ISSUE is one cycle, WAIT runs MEM_LAT cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (last_wait) state_d = RESP;
      RESP:    state_d = any_req ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request when an arbitration is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (arb_en && any_req) begin
      owner_q <= winner;
      if (winner == OWN_LS) begin
        addr_q  <= ls_addr;
        we_q    <= ls_we;
        wdata_q <= ls_wdata;
      end else begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // Latency counter: loaded on ISSUE, counts down through WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= '0;
    else if (state_q == ISSUE)   cnt_q <= CNT_W'(MEM_LAT);
    else if (state_q == WAIT)    cnt_q <= cnt_q - CNT_W'(1);
  end

  // Capture read data on the last WAIT cycle; writes leave the rdata registers alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else if (last_wait && !we_q) begin
      if (owner_q == OWN_LS) ls_rdata_q <= mem_rdata;
      else                   if_rdata_q <= mem_rdata;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt    = (state_q == ISSUE) && (owner_q == OWN_IF);
  assign ls_gnt    = (state_q == ISSUE) && (owner_q == OWN_LS);
  assign if_rvalid = (state_q == RESP)  && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == RESP)  && (owner_q == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule
